// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier for MULT/MULTU (HI/LO unit), one partial product per cycle.
// Optional MADD/MADDU accumulation into {hi,lo} is enabled by defining MULT_MADD_EN.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             madd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               load;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] result;

`ifdef MULT_MADD_EN
  logic madd_q, madd_d;
`else
  logic unused_madd;
  assign unused_madd = madd_i;
`endif

  // Carry out of the upper-half add is kept and shifted back into the accumulator.
  assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign prod = neg_q ? -acc_q : acc_q;

`ifdef MULT_MADD_EN
  assign result = madd_q ? ({hi_q, lo_q} + prod) : prod;
`else
  assign result = prod;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    load     = 1'b0;
`ifdef MULT_MADD_EN
    madd_d   = madd_q;
`endif

    unique case (state_q)
      StIdle: load = start_i;
      StRun: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        {hi_d, lo_d} = result;
        state_d      = StDone;
      end
      StDone: begin
        load    = start_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Operands are captured only from IDLE/DONE, so start during RUN/FIX is ignored.
    if (load) begin
      state_d  = StRun;
      cnt_d    = CntInit;
      mcand_d  = (is_signed_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
      mplier_d = (is_signed_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
      neg_d    = is_signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
      acc_d    = '0;
`ifdef MULT_MADD_EN
      madd_d   = madd_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_MADD_EN
      madd_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_MADD_EN
      madd_q   <= madd_d;
`endif
    end
  end

  assign busy_o = (state_q == StRun) || (state_q == StFix);
  assign done_o = (state_q == StDone);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus random ops against a
// plain-arithmetic product model that tracks the architectural {hi,lo} value.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        madd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;
  logic [63:0] model_hilo;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .is_signed_i(is_signed),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .madd_i     (madd),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full 64-bit product, optionally accumulated when the MADD feature is built in.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic m, input logic [63:0] prev);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      p  = sa * sb;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
`ifdef MULT_MADD_EN
    if (m) p = prev + p;
`else
    if (m) p = p + 64'd0;
    if (prev == 64'd0) p = p + prev;
`endif
    return p;
  endfunction

  // Launches one op and waits (bounded) for done; lat = posedges from the sampling edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic m, output int lat);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; is_signed = s; madd = m;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 200);
    model_hilo = model(a, b, s, m, model_hilo);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; madd = 1'b0;
    model_hilo = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu_max;
    int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_during_done got %b want 0", busy); end
  endtask

  task automatic test_mult_signed;
    int lat;
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, lat);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mult_m3x7 got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat);
    checks++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL mult_minmin got %h_%h want 40000000_00000000", hi, lo);
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
  endtask

  task automatic test_start_ignored;
    int dones;
    logic seen_busy;
    @(negedge clk);
    start = 1'b1; op_a = 32'd1000; op_b = 32'd3000; is_signed = 1'b0; madd = 1'b0;
    dones = 0; seen_busy = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (cyc == 3) seen_busy = busy;
      start = 1'b0;
      if (cyc == 4 || cyc == 11) begin
        start = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; is_signed = 1'b1;
      end
    end
    start = 1'b0;
    model_hilo = 64'd3_000_000;
    checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", seen_busy); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_dones got %0d want 1", dones); end
    checks++;
    if ({hi, lo} !== model_hilo) begin
      errors++; $display("FAIL ign_result got %h_%h want %h", hi, lo, model_hilo);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk);
    start = 1'b1; op_a = 32'd77; op_b = 32'd99; is_signed = 1'b0; madd = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got %h_%h want 0", hi, lo); end
    model_hilo = '0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int dones;
    run_op(32'd6, 32'd7, 1'b0, 1'b0, lat);
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_first got %0d want 42", lo); end
    // Still in the DONE cycle: start is sampled at the edge that ends it.
    start = 1'b1; op_a = 32'h1234; op_b = 32'd0; is_signed = 1'b0; madd = 1'b0;
    dones = 1; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
      end
      if (done) dones++;
    end while (!done && lat < 200);
    model_hilo = 64'd0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL b2b_second got %h want 0", lo); end
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_dones got %0d want 2", dones); end
  endtask

  task automatic test_madd;
    int lat;
    logic [31:0] want_lo;
    run_op(32'd1, 32'd5, 1'b0, 1'b0, lat);
    run_op(32'd2, 32'd3, 1'b0, 1'b1, lat);
`ifdef MULT_MADD_EN
    want_lo = 32'd11;
`else
    want_lo = 32'd6;
`endif
    checks++; if (lo !== want_lo) begin errors++; $display("FAIL madd_lo got %0d want %0d", lo, want_lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL madd_hi got %h want 0", hi); end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] a, b;
    logic s, m;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      if (i % 6 == 0) a = 32'h8000_0000;
      if (i % 7 == 3) b = 32'hFFFF_FFFF;
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      run_op(a, b, s, m, lat);
      checks++;
      if (lat !== 34 || {hi, lo} !== model_hilo) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h s=%b m=%b got %h_%h lat %0d want %h lat 34",
                 i, a, b, s, m, hi, lo, lat, model_hilo);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_multu_max;
    test_mult_signed;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_madd;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
